// File: rtl/dict_pkg.sv
// Shared encodings for the dictionary request/done interface and the dict_master FSM.
// Op codes are shared with the dictionary; is_fast_op() flags the single-cycle ops.
package dict_pkg;

    typedef enum logic [2:0] {
        OP_SET         = 3'd0,
        OP_GET         = 3'd1,
        OP_ENCODE      = 3'd2,
        OP_SET_FAST    = 3'd3,
        OP_GET_FAST    = 3'd4,
        OP_DELETE      = 3'd5,
        OP_DELETE_FAST = 3'd6,
        OP_ILLEGAL     = 3'd7
    } dict_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } dict_state_e;

    function automatic logic is_fast_op(input logic [2:0] op);
        return (op == OP_SET_FAST) || (op == OP_GET_FAST) || (op == OP_DELETE_FAST);
    endfunction

endpackage

// File: rtl/dict_master.sv
// Request/response initiator for the string-to-integer dictionary.
// Optional abort on a stuck dictionary: define DICT_MASTER_TIMEOUT_EN.
module dict_master
    import dict_pkg::*;
#(
    parameter int unsigned ENTRIES        = 10,
    parameter int unsigned ENTRIES_BITS   = $clog2(ENTRIES),
    parameter int unsigned KEY_WIDTH      = 8,
    parameter int unsigned KEY_LENGTH     = 1,
    parameter int unsigned VALUE_WIDTH    = 32,
    parameter int unsigned VALUE_LENGTH   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [2:0]              i_req_op,
    input  logic [KEY_WIDTH-1:0]    i_req_key   [KEY_LENGTH],
    input  logic [ENTRIES_BITS-1:0] i_req_index,
    input  logic [VALUE_WIDTH-1:0]  i_req_value [VALUE_LENGTH],

    output logic                    o_dict_ready,
    output logic [2:0]              o_dict_op,
    output logic [KEY_WIDTH-1:0]    o_dict_key   [KEY_LENGTH],
    output logic [ENTRIES_BITS-1:0] o_dict_index,
    output logic [VALUE_WIDTH-1:0]  o_dict_value [VALUE_LENGTH],
    input  logic                    i_dict_done,
    input  logic                    i_dict_err,
    input  logic [ENTRIES_BITS-1:0] i_dict_index,
    input  logic [VALUE_WIDTH-1:0]  i_dict_value [VALUE_LENGTH],

    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic                    o_rsp_err,
    output logic                    o_rsp_timeout,
    output logic [ENTRIES_BITS-1:0] o_rsp_index,
    output logic [VALUE_WIDTH-1:0]  o_rsp_value [VALUE_LENGTH],

    output logic [2:0]              d_state
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dict_master: TIMEOUT_CYCLES must be at least 1");
    end

    dict_state_e state;
    logic        to_expired;

    assign d_state = state;

`ifdef DICT_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_stay;

    // The counter only survives cycles where the FSM stays put, so it clears on every state change.
    assign to_stay    = ((state == S_DRAIN) &&  i_dict_done) ||
                        ((state == S_WAIT)  && !i_dict_done);
    assign to_expired = to_stay && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt <= '0;
        end else if (to_stay && !to_expired) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_timeout <= 1'b0;
        end else if ((state == S_IDLE) && i_req_valid) begin
            o_rsp_timeout <= 1'b0;
        end else if (to_expired) begin
            o_rsp_timeout <= 1'b1;
        end
    end
`else
    assign to_expired    = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            o_req_ready  <= 1'b1;
            o_dict_ready <= 1'b0;
            o_dict_op    <= '0;
            o_dict_key   <= '{default: '0};
            o_dict_index <= '0;
            o_dict_value <= '{default: '0};
            o_rsp_valid  <= 1'b0;
            o_rsp_err    <= 1'b0;
            o_rsp_index  <= '0;
            o_rsp_value  <= '{default: '0};
        end else begin
            o_dict_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        o_req_ready  <= 1'b0;
                        o_dict_op    <= i_req_op;
                        o_dict_key   <= i_req_key;
                        o_dict_index <= i_req_index;
                        o_dict_value <= i_req_value;
                        if (i_req_op == OP_ILLEGAL) begin
                            state       <= S_RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_index <= '0;
                            o_rsp_value <= '{default: '0};
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end

                // A done still high from the previous op must fall before issuing.
                S_DRAIN: begin
                    if (!i_dict_done) begin
                        state        <= S_ISSUE;
                        o_dict_ready <= 1'b1;
                    end else if (to_expired) begin
                        state       <= S_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_index <= '0;
                        o_rsp_value <= '{default: '0};
                    end
                end

                S_ISSUE: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (i_dict_done) begin
                        state       <= S_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= i_dict_err;
                        o_rsp_index <= i_dict_index;
                        o_rsp_value <= i_dict_value;
                    end else if (to_expired) begin
                        state       <= S_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_index <= '0;
                        o_rsp_value <= '{default: '0};
                    end
                end

                S_RESP: begin
                    if (i_rsp_ready) begin
                        state       <= S_IDLE;
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    o_rsp_valid <= 1'b0;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dict_master.sv
// Scoreboard bench for dict_master: directed requests push expectations, a monitor pops on responses.
// Define DICT_MASTER_TIMEOUT_EN to also exercise the timeout abort.
module tb_dict_master;
    import dict_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_req_op;
    logic [7:0]  i_req_key   [1];
    logic [3:0]  i_req_index;
    logic [31:0] i_req_value [1];
    logic        o_dict_ready;
    logic [2:0]  o_dict_op;
    logic [7:0]  o_dict_key   [1];
    logic [3:0]  o_dict_index;
    logic [31:0] o_dict_value [1];
    logic        i_dict_done;
    logic        i_dict_err;
    logic [3:0]  i_dict_index;
    logic [31:0] i_dict_value [1];
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic        o_rsp_err;
    logic        o_rsp_timeout;
    logic [3:0]  o_rsp_index;
    logic [31:0] o_rsp_value [1];
    logic [2:0]  d_state;

    always #5 i_clk = ~i_clk;

    dict_master #(
        .ENTRIES        (10),
        .KEY_WIDTH      (8),
        .KEY_LENGTH     (1),
        .VALUE_WIDTH    (32),
        .VALUE_LENGTH   (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_op      (i_req_op),
        .i_req_key     (i_req_key),
        .i_req_index   (i_req_index),
        .i_req_value   (i_req_value),
        .o_dict_ready  (o_dict_ready),
        .o_dict_op     (o_dict_op),
        .o_dict_key    (o_dict_key),
        .o_dict_index  (o_dict_index),
        .o_dict_value  (o_dict_value),
        .i_dict_done   (i_dict_done),
        .i_dict_err    (i_dict_err),
        .i_dict_index  (i_dict_index),
        .i_dict_value  (i_dict_value),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_err     (o_rsp_err),
        .o_rsp_timeout (o_rsp_timeout),
        .o_rsp_index   (o_rsp_index),
        .o_rsp_value   (o_rsp_value),
        .d_state       (d_state)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] val;
        logic [3:0]  idx;
        logic        err;
        logic        to;
        int          lat;
        int          strobes;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    always @(posedge i_clk) cyc++;

    // Bench dictionary: fast ops answer one cycle after the strobe, slow ops two.
    logic        rd_done   = 1'b0;
    logic        hold_done = 1'b0;
    logic        dict_mute = 1'b0;
    logic [31:0] kv       [256];
    logic [31:0] fast_tab [16];

    assign i_dict_done = rd_done | hold_done;

    initial begin
        for (int i = 0; i < 256; i++) kv[i] = '0;
        for (int i = 0; i < 16; i++) fast_tab[i] = '0;
        fast_tab[3] = 32'h0000_1234;
        fast_tab[7] = 32'hCAFE_0007;
        i_dict_err      = 1'b0;
        i_dict_index    = '0;
        i_dict_value[0] = '0;
    end

    always begin
        logic [2:0]  op;
        logic [7:0]  k;
        logic [31:0] rv;
        logic [3:0]  ri;
        logic        re;
        @(negedge i_clk);
        if (o_dict_ready && !dict_mute) begin
            op = o_dict_op;
            k  = o_dict_key[0];
            rv = '0; ri = '0; re = 1'b0;
            case (op)
                OP_SET:      begin kv[k] = o_dict_value[0]; rv = o_dict_value[0]; ri = 4'(k % 8'd10); end
                OP_GET:      begin rv = kv[k]; ri = 4'(k % 8'd10); end
                OP_GET_FAST: begin rv = fast_tab[o_dict_index]; ri = o_dict_index; end
                default:     re = 1'b1;
            endcase
            if (!is_fast_op(op)) @(posedge i_clk);
            @(posedge i_clk); #1;
            rd_done = 1'b1; i_dict_err = re; i_dict_index = ri; i_dict_value[0] = rv;
            @(posedge i_clk); #1;
            rd_done = 1'b0;
        end
    end

    // Monitor: pops one expectation per response and checks it while held.
    int   acc_cyc     = 0;
    int   nstrobe     = 0;
    logic prev_strobe = 1'b0;
    logic rsp_open    = 1'b0;
    exp_t cur;

    always @(negedge i_clk) begin
        if (i_rst) begin
            rsp_open    = 1'b0;
            prev_strobe = 1'b0;
        end else begin
            if (o_dict_ready) begin
                nstrobe++;
                chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
                chk("strobe_after_drain", {31'd0, i_dict_done}, 32'd0);
                if (exp_q.size() > 0) chk("dict_op", {29'd0, o_dict_op}, {29'd0, exp_q[0].op});
            end
            prev_strobe = o_dict_ready;
            if (o_rsp_valid) begin
                if (!rsp_open) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        rsp_open = 1'b1;
                        chk("rsp_value",   o_rsp_value[0], cur.val);
                        chk("rsp_index",   {28'd0, o_rsp_index}, {28'd0, cur.idx});
                        chk("rsp_err",     {31'd0, o_rsp_err}, {31'd0, cur.err});
                        chk("rsp_timeout", {31'd0, o_rsp_timeout}, {31'd0, cur.to});
                        chk("latency",     32'(cyc - acc_cyc + 1), 32'(cur.lat));
                        chk("strobes",     32'(nstrobe), 32'(cur.strobes));
                    end
                end else begin
                    chk("hold_value",     o_rsp_value[0], cur.val);
                    chk("hold_index",     {28'd0, o_rsp_index}, {28'd0, cur.idx});
                    chk("hold_err",       {31'd0, o_rsp_err}, {31'd0, cur.err});
                    chk("hold_req_ready", {31'd0, o_req_ready}, 32'd0);
                end
                if (i_rsp_ready) rsp_open = 1'b0;
            end
            if (i_req_valid && o_req_ready) begin
                acc_cyc = cyc + 1;
                nstrobe = 0;
            end
        end
    end

    task automatic push(input logic [2:0] op, input logic [31:0] val, input logic [3:0] idx,
                        input logic err, input logic to, input int lat, input int strobes);
        exp_t e;
        e.op = op; e.val = val; e.idx = idx; e.err = err; e.to = to; e.lat = lat; e.strobes = strobes;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] key, input logic [3:0] idx,
                        input logic [31:0] val, output int waits);
        i_req_op = op; i_req_key[0] = key; i_req_index = idx; i_req_value[0] = val;
        i_req_valid = 1'b1;
        waits = 0;
        @(negedge i_clk);
        while (!o_req_ready && waits < 50) begin
            waits++;
            @(negedge i_clk);
        end
        if (!o_req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge i_clk);
        while (!(exp_q.size() == 0 && o_req_ready && !o_rsp_valid) && n < 100) begin
            n++;
            @(negedge i_clk);
        end
        if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge i_clk); #1;
    endtask

    task automatic check_reset(input string p);
        chk({p, "state"},      {29'd0, d_state}, 32'd0);
        chk({p, "req_ready"},  {31'd0, o_req_ready}, 32'd1);
        chk({p, "dict_ready"}, {31'd0, o_dict_ready}, 32'd0);
        chk({p, "rsp_valid"},  {31'd0, o_rsp_valid}, 32'd0);
        chk({p, "rsp_err"},    {31'd0, o_rsp_err}, 32'd0);
        chk({p, "rsp_to"},     {31'd0, o_rsp_timeout}, 32'd0);
        chk({p, "rsp_index"},  {28'd0, o_rsp_index}, 32'd0);
        chk({p, "rsp_value"},  o_rsp_value[0], 32'd0);
        chk({p, "dict_op"},    {29'd0, o_dict_op}, 32'd0);
        chk({p, "dict_key"},   {24'd0, o_dict_key[0]}, 32'd0);
        chk({p, "dict_index"}, {28'd0, o_dict_index}, 32'd0);
        chk({p, "dict_value"}, o_dict_value[0], 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got stuck want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        i_rst = 1'b1; i_req_valid = 1'b0; i_req_op = '0; i_req_key[0] = '0;
        i_req_index = '0; i_req_value[0] = '0; i_rsp_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_reset("rst_");
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        push(OP_GET_FAST, 32'h1234, 4'd3, 1'b0, 1'b0, 4, 1);
        send(OP_GET_FAST, 8'h00, 4'd3, 32'd0, w);
        wait_idle();

        push(OP_SET, 32'd7, 4'd5, 1'b0, 1'b0, 5, 1);
        send(OP_SET, 8'h41, 4'd0, 32'd7, w);
        wait_idle();
        push(OP_GET, 32'd7, 4'd5, 1'b0, 1'b0, 5, 1);
        send(OP_GET, 8'h41, 4'd0, 32'd0, w);
        wait_idle();

        push(OP_ILLEGAL, 32'd0, 4'd0, 1'b1, 1'b0, 1, 0);
        send(OP_ILLEGAL, 8'h55, 4'd9, 32'hFFFF_FFFF, w);
        wait_idle();

        // Stale done held across accept: three extra drain cycles.
        hold_done = 1'b1;
        push(OP_GET_FAST, 32'hCAFE_0007, 4'd7, 1'b0, 1'b0, 7, 1);
        send(OP_GET_FAST, 8'h00, 4'd7, 32'd0, w);
        repeat (3) @(posedge i_clk);
        #1;
        hold_done = 1'b0;
        wait_idle();

        // Consumer back-pressure, then an immediate follow-up request.
        i_rsp_ready = 1'b0;
        push(OP_GET_FAST, 32'h1234, 4'd3, 1'b0, 1'b0, 4, 1);
        send(OP_GET_FAST, 8'h00, 4'd3, 32'd0, w);
        n = 0;
        @(negedge i_clk);
        while (!o_rsp_valid && n < 20) begin
            n++;
            @(negedge i_clk);
        end
        if (!o_rsp_valid) chk("rsp_wait_timeout", 32'd0, 32'd1);
        repeat (5) @(negedge i_clk);
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b1;
        push(OP_ILLEGAL, 32'd0, 4'd0, 1'b1, 1'b0, 1, 0);
        send(OP_ILLEGAL, 8'h00, 4'd0, 32'd0, w);
        chk("accept_after_release", 32'(w), 32'd1);
        wait_idle();

`ifdef DICT_MASTER_TIMEOUT_EN
        dict_mute = 1'b1;
        push(OP_GET, 32'd0, 4'd0, 1'b1, 1'b1, 19, 1);
        send(OP_GET, 8'h41, 4'd0, 32'd0, w);
        wait_idle();
        dict_mute = 1'b0;
`endif

        // Reset while waiting on a silent dictionary.
        dict_mute = 1'b1;
        send(OP_GET, 8'h41, 4'd2, 32'h99, w);
        n = 0;
        @(negedge i_clk);
        while (d_state != 3'd3 && n < 20) begin
            n++;
            @(negedge i_clk);
        end
        chk("reached_wait", {29'd0, d_state}, 32'd3);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        check_reset("mid_");
        i_rst = 1'b0;
        dict_mute = 1'b0;
        @(posedge i_clk); #1;

        push(OP_GET, 32'd7, 4'd5, 1'b0, 1'b0, 5, 1);
        send(OP_GET, 8'h41, 4'd0, 32'd0, w);
        wait_idle();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dict_master.md
Name: dict_master

Overview:
- Initiator for the string-to-integer dictionary's request/done interface.
- Accepts one op request from a Forth control unit (tokenizer, interpreter, compiler) on a valid/ready handshake and latches its operands.
- Drives the dictionary's ready/op/key/index/value for exactly one cycle, waits for done, captures value/index/err, and returns them on a valid/ready response channel.
- Sits between the interpreter core and the dictionary; the interpreter never touches dictionary timing directly.

Parameters:
- ENTRIES, 10, number of dictionary entries; ENTRIES_BITS = $clog2(ENTRIES).
- KEY_WIDTH, 8, bits per key element.
- KEY_LENGTH, 1, elements per key.
- VALUE_WIDTH, 32, bits per value element.
- VALUE_LENGTH, 1, elements per value.
- TIMEOUT_CYCLES, 16, max WAIT/DRAIN cycles before abort; only used with DICT_MASTER_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high, sampled on rising i_clk.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  master can accept; high only in S_IDLE.
- i_req_op  in  3  0 SET, 1 GET, 2 ENCODE, 3 SET_FAST, 4 GET_FAST, 5 DELETE, 6 DELETE_FAST, 7 illegal.
- i_req_key  in  [KEY_WIDTH-1:0] x KEY_LENGTH (unpacked)  key.
- i_req_index  in  ENTRIES_BITS  index for *_FAST ops.
- i_req_value  in  [VALUE_WIDTH-1:0] x VALUE_LENGTH  value for SET.
- o_dict_ready  out  1  one-cycle issue strobe to dictionary.
- o_dict_op  out  3  latched op.
- o_dict_key / o_dict_index / o_dict_value  out  as request  latched operands, held stable from S_ISSUE until the next accept.
- i_dict_done  in  1  dictionary done.
- i_dict_err  in  1  dictionary error.
- i_dict_index  in  ENTRIES_BITS  dictionary result index.
- i_dict_value  in  [VALUE_WIDTH-1:0] x VALUE_LENGTH  dictionary result value.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer takes response.
- o_rsp_err  out  1  dictionary error, illegal op, or timeout.
- o_rsp_timeout  out  1  abort due to timeout.
- o_rsp_index / o_rsp_value  out  as dictionary  captured results.
- d_state  out  3  current state, for debug.

Behaviour:
- Reset: synchronous, active-high, highest priority, aborts any operation.
  - Clears all outputs and operand/result registers to 0.
  - Returns to S_IDLE: o_req_ready=1, o_dict_ready=0, o_rsp_valid=0.
- States: S_IDLE=0, S_DRAIN=1, S_ISSUE=2, S_WAIT=3, S_RESP=4.
- S_IDLE: on i_req_valid, latch op and operands.
  - op==7: go to S_RESP with err=1, index=0, value=0; nothing is issued to the dictionary.
  - Otherwise go to S_DRAIN.
- S_DRAIN: wait until i_dict_done==0, so a stale done from the previous op is never taken as completion. If i_dict_done==0 on entry, leave after that single cycle and go to S_ISSUE.
- S_ISSUE: o_dict_ready=1 for exactly this one cycle, then go to S_WAIT. o_dict_ready is never high in any other state.
- S_WAIT: on i_dict_done==1, capture i_dict_err, i_dict_index and i_dict_value, then go to S_RESP.
  - Fast ops complete on the first S_WAIT cycle.
  - SET/GET/ENCODE/DELETE complete on the second.
- S_RESP: o_rsp_valid=1 with all response fields stable; go to S_IDLE when i_rsp_ready==1. Back-to-back requests are accepted from the following cycle.
- Latency, accept edge to o_rsp_valid:
  - Fast op: 4 cycles.
  - Slow op: 5 cycles.
  - Illegal op: 1 cycle.
- i_req_valid outside S_IDLE is ignored. i_dict_done outside S_WAIT/S_DRAIN is ignored.
- o_rsp_timeout=0 except as described under Optional Feature.

Optional Feature:
- Macro: DICT_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in S_DRAIN and S_WAIT and clears on every state change.
  - When it reaches TIMEOUT_CYCLES without the exit condition, go to S_RESP with err=1, timeout=1, index=0, value=0.
- Undefined: no counter; the block waits indefinitely; o_rsp_timeout is tied to 0.

Decomposition:
- Package dict_pkg holds:
  - OP_* encodings (shared with the dictionary).
  - S_* state constants.
  - An OP_ILLEGAL=7 constant.
  - A function is_fast_op(op) for bench latency checks.
- No sub-module; the timeout counter stays inline.

Test Plan:
- GET_FAST, index=3, bench dictionary returns done one cycle after strobe with value=0x1234 -> o_dict_ready high exactly 1 cycle; o_rsp_valid 4 cycles after accept; value=0x1234, index=3, err=0.
- SET key=0x41, value=7, then GET key=0x41, dictionary done two cycles after strobe -> two separate one-cycle strobes; GET response value=7, err=0, latency 5.
- op=7 -> no strobe; o_rsp_valid next cycle with err=1, timeout=0.
- i_dict_done held at 1 at accept, released after 3 cycles -> strobe occurs only after done falls; correct result captured afterwards.
- i_rsp_ready held low for 5 cycles -> response fields stable and o_req_ready=0 throughout; a new request is accepted the cycle after release.
- DICT_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, dictionary never answers -> response err=1, timeout=1, 16 cycles after entering S_WAIT. Separately, i_rst asserted mid-S_WAIT -> S_IDLE next cycle, all outputs 0.
